// File: rtl/hier_path_pkg.sv
// Shared definitions for the hierarchical path decoder: default geometry,
// derived field widths, FSM state encoding and a constant power helper.
package hier_path_pkg;

    localparam int DEF_FANOUT  = 5;
    localparam int DEF_DEPTH   = 10;
    localparam int DEF_IDX_W   = 24;
    localparam int DEF_DIGIT_W = $clog2(DEF_FANOUT);
    localparam int DEF_LEVEL_W = $clog2(DEF_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RANGE,
        DIVIDE,
        EMIT
    } state_e;

    typedef logic [DEF_DIGIT_W-1:0] digit_t;

    // Integer power used to size the number of addressable leaves.
    function automatic longint unsigned ipow(input int unsigned base, input int unsigned exp);
        longint unsigned acc;
        acc = 1;
        for (int unsigned i = 0; i < exp; i++) begin
            acc = acc * longint'(base);
        end
        return acc;
    endfunction

endpackage

// File: rtl/hier_path_divider.sv
// Sequential restoring divider by a constant DIVISOR. One quotient bit is
// produced per cycle; the cycle that asserts start_i already performs the
// first step, so back-to-back divisions need no idle cycle in between.
// done_o is high for exactly one cycle once all WIDTH bits are resolved.
module hier_path_divider #(
    parameter int WIDTH   = 24,
    parameter int DIVISOR = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic [WIDTH-1:0]           dividend_i,
    output logic                       done_o,
    output logic [WIDTH-1:0]           quotient_o,
    output logic [$clog2(DIVISOR)-1:0] remainder_o
);

    localparam int RW = $clog2(DIVISOR);
    localparam int CW = $clog2(WIDTH + 1);

    logic [RW-1:0]    rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;

    logic [RW-1:0]    srcRem;
    logic [WIDTH-1:0] srcQuo;
    logic [RW:0]      trial;
    logic [RW:0]      diff;
    logic [RW-1:0]    rem_d;
    logic [WIDTH-1:0] quo_d;

    // One shift-subtract step, seeded from the new dividend when starting.
    always_comb begin
        srcRem = start_i ? '0 : rem_q;
        srcQuo = start_i ? dividend_i : quo_q;
        trial  = {srcRem, srcQuo[WIDTH-1]};
        diff   = trial - (RW+1)'(DIVISOR);
        if (trial >= (RW+1)'(DIVISOR)) begin
            rem_d = diff[RW-1:0];
            quo_d = {srcQuo[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = trial[RW-1:0];
            quo_d = {srcQuo[WIDTH-2:0], 1'b0};
        end
    end

    // Advance the division until all bits are done, then drop busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            cnt_q  <= CW'(1);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            if (cnt_q != CW'(WIDTH)) begin
                rem_q <= rem_d;
                quo_q <= quo_d;
                cnt_q <= cnt_q + CW'(1);
            end else begin
                busy_q <= 1'b0;
            end
        end
    end

    assign done_o      = busy_q && (cnt_q == CW'(WIDTH));
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/hier_path_decoder.sv
// Converts a flat leaf index into its per-level instance path. Digits are
// computed deepest level first by repeated division by FANOUT, buffered,
// then streamed out level 0 first over a valid/ready handshake.
// Optional feature: define HIER_PATH_DECODER_RANGE_CHECK_EN to reject
// indices >= FANOUT**DEPTH with a one-cycle err pulse. Without it err is
// tied low and the level-0 digit is the low bits of the last quotient.
module hier_path_decoder
    import hier_path_pkg::*;
#(
    parameter int FANOUT = DEF_FANOUT,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int IDX_W  = DEF_IDX_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IDX_W-1:0]          in_index,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH)-1:0]  out_level,
    output logic [$clog2(FANOUT)-1:0] out_digit,
    output logic                      out_last,
    output logic                      err
);

    localparam int DW = $clog2(FANOUT);
    localparam int LW = $clog2(DEPTH);

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [LW-1:0]    divLevel_q;
    logic [DW-1:0]    digitBuf_q [DEPTH];
    logic             outValid_q;
    logic [LW-1:0]    outLevel_q;
    logic [DW-1:0]    outDigit_q;
    logic             outLast_q;
    logic [LW-1:0]    nextLevel_d;

    logic             rangeOk;
    logic             divStart;
    logic [IDX_W-1:0] divDividend;
    logic             divDone;
    logic [IDX_W-1:0] divQuotient;
    logic [DW-1:0]    divRemainder;
    logic [DW-1:0]    lvl0Digit;

`ifdef HIER_PATH_DECODER_RANGE_CHECK_EN
    localparam longint unsigned LEAF_COUNT = ipow(FANOUT, DEPTH);
    logic err_q;
    assign rangeOk   = (64'(idx_q) < LEAF_COUNT);
    assign lvl0Digit = divRemainder;
    assign err       = err_q;
`else
    assign rangeOk   = 1'b1;
    assign lvl0Digit = digitBuf_q[0];
    assign err       = 1'b0;
`endif

    // Kick the divider from RANGE, and chain each quotient into the next level.
    always_comb begin
        divStart    = ((state_q == RANGE) && rangeOk) ||
                      ((state_q == DIVIDE) && divDone && (divLevel_q != '0));
        divDividend = (state_q == RANGE) ? idx_q : divQuotient;
        nextLevel_d = outLevel_q + LW'(1);
    end

    hier_path_divider #(
        .WIDTH   (IDX_W),
        .DIVISOR (FANOUT)
    ) u_divider (
        .clk         (clk),
        .rst         (rst),
        .start_i     (divStart),
        .dividend_i  (divDividend),
        .done_o      (divDone),
        .quotient_o  (divQuotient),
        .remainder_o (divRemainder)
    );

    // Main control: accept, range check, collect digits, stream them out.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            divLevel_q <= '0;
            outValid_q <= 1'b0;
            outLevel_q <= '0;
            outDigit_q <= '0;
            outLast_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                digitBuf_q[i] <= '0;
            end
`ifdef HIER_PATH_DECODER_RANGE_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
`ifdef HIER_PATH_DECODER_RANGE_CHECK_EN
            err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        idx_q   <= in_index;
                        state_q <= RANGE;
                    end
                end
                RANGE: begin
                    if (rangeOk) begin
                        divLevel_q <= LW'(DEPTH - 1);
                        state_q    <= DIVIDE;
                    end else begin
`ifdef HIER_PATH_DECODER_RANGE_CHECK_EN
                        err_q      <= 1'b1;
`endif
                        state_q    <= IDLE;
                    end
                end
                DIVIDE: begin
                    if (divDone) begin
`ifdef HIER_PATH_DECODER_RANGE_CHECK_EN
                        digitBuf_q[divLevel_q] <= divRemainder;
`else
                        if (divLevel_q != '0) begin
                            digitBuf_q[divLevel_q] <= divRemainder;
                        end
                        if (divLevel_q == LW'(1)) begin
                            digitBuf_q[0] <= divQuotient[DW-1:0];
                        end
`endif
                        if (divLevel_q == '0) begin
                            outValid_q <= 1'b1;
                            outLevel_q <= '0;
                            outDigit_q <= lvl0Digit;
                            outLast_q  <= (DEPTH == 1);
                            state_q    <= EMIT;
                        end else begin
                            divLevel_q <= divLevel_q - LW'(1);
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (outLast_q) begin
                            outValid_q <= 1'b0;
                            outLevel_q <= '0;
                            outDigit_q <= '0;
                            outLast_q  <= 1'b0;
                            state_q    <= IDLE;
                        end else begin
                            outLevel_q <= nextLevel_d;
                            outDigit_q <= digitBuf_q[nextLevel_d];
                            outLast_q  <= (nextLevel_d == LW'(DEPTH - 1));
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = outValid_q;
    assign out_level = outLevel_q;
    assign out_digit = outDigit_q;
    assign out_last  = outLast_q;

endmodule

// File: tb/tb_hier_path_decoder.sv
// Self-checking bench for hier_path_decoder: directed vector table, a reset
// abort sequence and randomized indices checked against an arithmetic model.
// Decoded paths are packed as decimal numbers, level 0 most significant.
module tb_hier_path_decoder;

   localparam int FANOUT = 5;
   localparam int DEPTH  = 10;
   localparam int IDX_W  = 24;
   localparam int LATENCY = 1 + DEPTH * IDX_W;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      in_valid;
   logic                      in_ready;
   logic [IDX_W-1:0]          in_index;
   logic                      out_valid;
   logic                      out_ready;
   logic [$clog2(DEPTH)-1:0]  out_level;
   logic [$clog2(FANOUT)-1:0] out_digit;
   logic                      out_last;
   logic                      err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int unsigned index;
      int          stallLevel;
      int          stallCycles;
      bit          pulseIn;
      longint      expPath;
      bit          expErr;
   } vec_t;

   vec_t vecs[$];

   hier_path_decoder dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_index  (in_index),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_level (out_level),
      .out_digit (out_digit),
      .out_last  (out_last),
      .err       (err)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   function automatic longint pow10(input int e);
      longint p;
      p = 1;
      for (int i = 0; i < e; i++) p = p * 10;
      return p;
   endfunction

   // Reference: digit(k) = floor(index / FANOUT**(DEPTH-1-k)) mod FANOUT.
   function automatic longint modelPath(input longint idx);
      longint p, d, path;
      path = 0;
      for (int k = 0; k < DEPTH; k++) begin
         p = 1;
         for (int j = 0; j < DEPTH - 1 - k; j++) p = p * FANOUT;
         d = idx / p;
`ifdef HIER_PATH_DECODER_RANGE_CHECK_EN
         d = d % FANOUT;
`else
         if (k == 0) d = d % 8;
         else d = d % FANOUT;
`endif
         path = path * 10 + d;
      end
      return path;
   endfunction

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   // Run one full transaction and report what the decoder produced.
   task automatic applyStimulus(input int unsigned idx, input int stallLevel, input int stallCycles,
                                input bit pulseIn, output longint path, output int latency,
                                output int errCycles, output bit seqOk, output bit holdOk,
                                output bit readyOk, output int nDigits, output bit timedOut);
      int cyc, expLevel, stallCnt, heldDigit, firstErr;
      bit done, heldSet;
      path = 0; latency = -1; errCycles = 0; seqOk = 1; holdOk = 1; readyOk = 1;
      nDigits = 0; timedOut = 0; expLevel = 0; stallCnt = 0; heldDigit = 0;
      firstErr = -1; done = 0; heldSet = 0;
      out_ready = 1'b1;
      cyc = 0;
      while (!in_ready && cyc < 50) begin
         @(posedge clk); #1; cyc++;
      end
      if (!in_ready) timedOut = 1;
      in_valid = 1'b1;
      in_index = IDX_W'(idx);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_index = IDX_W'($urandom);
      cyc = 0;
      while (!done && cyc < 2000) begin
         @(posedge clk); #1; cyc++;
         in_valid = 1'b0;
         if (err) begin
            errCycles++;
            if (firstErr < 0) firstErr = cyc;
            if (!in_ready) readyOk = 0;
         end
         if (out_valid) begin
            if (latency < 0) begin
               latency = cyc;
               if (pulseIn) begin
                  in_valid = 1'b1;
                  in_index = IDX_W'(5);
               end
            end
            if (in_ready) readyOk = 0;
            if (int'(out_level) != expLevel) seqOk = 0;
            if (out_last != (expLevel == DEPTH - 1)) seqOk = 0;
            if (int'(out_level) == stallLevel && stallCnt < stallCycles) begin
               if (!heldSet) begin
                  heldDigit = int'(out_digit);
                  heldSet = 1;
               end else if (int'(out_digit) != heldDigit) holdOk = 0;
               stallCnt++;
               out_ready = 1'b0;
            end else begin
               if (heldSet && int'(out_level) == stallLevel && int'(out_digit) != heldDigit) holdOk = 0;
               out_ready = 1'b1;
               if (expLevel < DEPTH) path = path + longint'(out_digit) * pow10(DEPTH - 1 - expLevel);
               nDigits++;
               expLevel++;
               if (out_last) done = 1;
            end
         end
         if (firstErr >= 0 && cyc >= firstErr + 5) done = 1;
      end
      if (!done) timedOut = 1;
      out_ready = 1'b1;
      in_valid = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
         if (out_valid) nDigits++;
         if (err) errCycles++;
      end
   endtask

   task automatic runAndCheck(input string tag, input int unsigned idx, input int stallLevel,
                              input int stallCycles, input bit pulseIn, input longint expPath,
                              input bit expErr);
      longint path;
      int latency, errCycles, nDigits;
      bit seqOk, holdOk, readyOk, timedOut;
      applyStimulus(idx, stallLevel, stallCycles, pulseIn, path, latency, errCycles,
                    seqOk, holdOk, readyOk, nDigits, timedOut);
      checkOutput({tag, "_timeout"}, timedOut, 0);
      checkOutput({tag, "_errcycles"}, errCycles, expErr ? 1 : 0);
      checkOutput({tag, "_ndigits"}, nDigits, expErr ? 0 : DEPTH);
      checkOutput({tag, "_latency"}, latency, expErr ? -1 : LATENCY);
      checkOutput({tag, "_ready"}, readyOk, 1);
      if (!expErr) begin
         checkOutput({tag, "_path"}, path, expPath);
         checkOutput({tag, "_order"}, seqOk, 1);
         checkOutput({tag, "_hold"}, holdOk, 1);
      end
   endtask

   initial begin
      int validSeen;
      int unsigned idx;
      rst = 1'b1;
      in_valid = 1'b0;
      in_index = '0;
      out_ready = 1'b1;

      vecs.push_back('{0,        -1, 0, 1'b0, 64'd0,          1'b0});
      vecs.push_back('{273,      -1, 0, 1'b0, 64'd2043,       1'b0});
      vecs.push_back('{9765624,  -1, 0, 1'b0, 64'd4444444444, 1'b0});
      vecs.push_back('{12345,     3, 5, 1'b0, 64'd343340,     1'b0});
      vecs.push_back('{1953125,  -1, 0, 1'b1, 64'd1000000000, 1'b0});
`ifdef HIER_PATH_DECODER_RANGE_CHECK_EN
      vecs.push_back('{9765625,  -1, 0, 1'b0, 64'd0,          1'b1});
`else
      vecs.push_back('{9765625,  -1, 0, 1'b0, 64'd5000000000, 1'b0});
      vecs.push_back('{16777215, -1, 0, 1'b0, 64'd243332330,  1'b0});
`endif

      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_in_ready", in_ready, 1);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_level", out_level, 0);
      checkOutput("rst_out_digit", out_digit, 0);
      checkOutput("rst_out_last", out_last, 0);
      checkOutput("rst_err", err, 0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         runAndCheck($sformatf("vec%0d", i), vecs[i].index, vecs[i].stallLevel,
                     vecs[i].stallCycles, vecs[i].pulseIn, vecs[i].expPath, vecs[i].expErr);
      end

      // Abort a decode partway through division, then reuse the decoder.
      in_valid = 1'b1;
      in_index = IDX_W'(273);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (101) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("abort_in_ready", in_ready, 1);
      checkOutput("abort_out_valid", out_valid, 0);
      checkOutput("abort_out_level", out_level, 0);
      checkOutput("abort_out_digit", out_digit, 0);
      checkOutput("abort_out_last", out_last, 0);
      checkOutput("abort_err", err, 0);
      validSeen = 0;
      repeat (300) begin
         @(posedge clk); #1;
         if (out_valid) validSeen++;
      end
      checkOutput("abort_no_digits", validSeen, 0);
      runAndCheck("after_abort", 273, -1, 0, 1'b0, 64'd2043, 1'b0);

      // Random indices against the arithmetic model.
      for (int r = 0; r < 8; r++) begin
`ifdef HIER_PATH_DECODER_RANGE_CHECK_EN
         idx = $urandom_range(0, 9765624);
`else
         if (r % 4 == 3) idx = $urandom_range(0, 16777215);
         else idx = $urandom_range(0, 9765624);
`endif
         runAndCheck($sformatf("rand%0d_idx%0d", r, idx), idx,
                     int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 3)),
                     1'b0, modelPath(longint'(idx)), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
